// File: rtl/snake_run_ctrl.sv
// Start/pause button conditioning and run/pause FSM for the LED snake game.
// Emits the run level, three single-clk step strobes and a long-press soft clear.
module snake_run_ctrl #(
    parameter int DEB_DIV_W    = 16,
    parameter int DEB_N        = 4,
    parameter int HOLD_SAMPLES = 1536,
    parameter int FAST_W       = 24,
    parameter int MID_W        = 25,
    parameter int SLOW_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       btn_level,
    output logic       en,
    output logic       tick_fast,
    output logic       tick_mid,
    output logic       tick_slow,
    output logic       soft_clr,
    output logic [1:0] state
);
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [1:0]           sync_r;
    logic [DEB_DIV_W-1:0] pre_r;
    logic [DEB_N-1:0]     shift_r;
    logic                 level_r;
    logic                 level_d_r;
    logic [HOLD_W-1:0]    hold_r;
    logic                 long_done_r;
    logic                 short_r;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [SLOW_W-1:0]    cnt_r;
    logic [SLOW_W-1:0]    cnt_nxt_s;
    logic                 en_r;
    logic                 tick_fast_r;
    logic                 tick_mid_r;
    logic                 tick_slow_r;
    logic                 soft_clr_r;
    logic                 sample_stb_s;
    logic                 long_hit_s;
    logic                 en_nxt_s;

    assign sample_stb_s = &pre_r;
    // The hold counter is about to reach HOLD_SAMPLES; only possible once per press.
    assign long_hit_s   = sample_stb_s & level_r & (hold_r == HOLD_W'(HOLD_SAMPLES - 1));
    assign en_nxt_s     = (state_nxt_s == RUN);

    assign btn_level = level_r;
    assign en        = en_r;
    assign tick_fast = tick_fast_r;
    assign tick_mid  = tick_mid_r;
    assign tick_slow = tick_slow_r;
    assign soft_clr  = soft_clr_r;
    assign state     = state_r;

    // Synchronizer, sample prescaler and shift-register debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r    <= 2'b00;
            pre_r     <= '0;
            shift_r   <= '0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], btn};
            pre_r     <= pre_r + DEB_DIV_W'(1'b1);
            if (sample_stb_s) begin
                shift_r <= {shift_r[DEB_N-2:0], sync_r[1]};
            end
            if (&shift_r) begin
                level_r <= 1'b1;
            end else if (~|shift_r) begin
                level_r <= 1'b0;
            end
            level_d_r <= level_r;
        end
    end

    // Press classification: saturating hold count, long-press latch, short-press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r      <= '0;
            long_done_r <= 1'b0;
            short_r     <= 1'b0;
        end else begin
            if (!level_r) begin
                hold_r <= '0;
            end else if (sample_stb_s && (hold_r != HOLD_W'(HOLD_SAMPLES))) begin
                hold_r <= hold_r + HOLD_W'(1'b1);
            end
            if (long_hit_s) begin
                long_done_r <= 1'b1;
            end else if (!level_r) begin
                long_done_r <= 1'b0;
            end
            // A release that ends a long press is swallowed here.
            short_r <= level_d_r & ~level_r & ~long_done_r;
        end
    end

    // Next state and tick counter; a long press overrides a coincident short press.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (long_hit_s) begin
            state_nxt_s = IDLE;
        end else if (short_r) begin
            case (state_r)
                IDLE:    state_nxt_s = RUN;
                RUN:     state_nxt_s = PAUSE;
                PAUSE:   state_nxt_s = RUN;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        if (long_hit_s) begin
            cnt_nxt_s = '0;
        end else begin
            case (state_r)
                IDLE:    cnt_nxt_s = '0;
                RUN:     cnt_nxt_s = cnt_r + SLOW_W'(1'b1);
                PAUSE:   cnt_nxt_s = cnt_r;
                default: cnt_nxt_s = '0;
            endcase
        end
    end

    // State, counter and all game-facing outputs, registered from the next-state view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            en_r        <= 1'b0;
            tick_fast_r <= 1'b0;
            tick_mid_r  <= 1'b0;
            tick_slow_r <= 1'b0;
            soft_clr_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            en_r        <= en_nxt_s;
            tick_fast_r <= en_nxt_s & (&cnt_nxt_s[FAST_W-1:0]);
            tick_mid_r  <= en_nxt_s & (&cnt_nxt_s[MID_W-1:0]);
            tick_slow_r <= en_nxt_s & (&cnt_nxt_s);
            soft_clr_r  <= long_hit_s;
        end
    end

endmodule

// File: tb/tb_snake_run_ctrl.sv
// Self-checking bench for snake_run_ctrl: scenario tasks compared every cycle
// against a reference that tracks sample run-lengths and RUN cycles since the last clear.
module tb_snake_run_ctrl;
    localparam int DEB_DIV_W    = 2;
    localparam int DEB_N        = 4;
    localparam int HOLD_SAMPLES = 8;
    localparam int FAST_W       = 3;
    localparam int MID_W        = 4;
    localparam int SLOW_W       = 5;
    localparam int PRE          = 1 << DEB_DIV_W;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       btn_level;
    logic       en;
    logic       tick_fast;
    logic       tick_mid;
    logic       tick_slow;
    logic       soft_clr;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    snake_run_ctrl #(
        .DEB_DIV_W(DEB_DIV_W), .DEB_N(DEB_N), .HOLD_SAMPLES(HOLD_SAMPLES),
        .FAST_W(FAST_W), .MID_W(MID_W), .SLOW_W(SLOW_W)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .btn_level(btn_level), .en(en),
        .tick_fast(tick_fast), .tick_mid(tick_mid), .tick_slow(tick_slow),
        .soft_clr(soft_clr), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic       m_b1, m_b2, m_run_val, m_lvl, m_lvl_d, m_long_done, m_short;
    logic       m_en, m_tf, m_tm, m_ts, m_sc;
    logic [1:0] m_st, mn_st;
    logic       m_stb, m_hit;
    int         m_cyc, m_run_len, m_hold, m_runs, mn_runs;
    logic [7:0] dut_v, exp_v;

    assign dut_v = {btn_level, en, tick_fast, tick_mid, tick_slow, soft_clr, state};
    assign exp_v = {m_lvl, m_en, m_tf, m_tm, m_ts, m_sc, m_st};

    // Reference next values: sampling instant, long-press instant, game state and progress.
    always_comb begin
        m_stb   = (m_cyc % PRE) == PRE - 1;
        m_hit   = m_stb && m_lvl && (m_hold == HOLD_SAMPLES - 1);
        mn_st   = m_st;
        mn_runs = m_runs;
        if (m_hit) mn_st = 2'd0;
        else if (m_short) mn_st = (m_st == 2'd1) ? 2'd2 : 2'd1;
        if (m_hit || m_st == 2'd0) mn_runs = 0;
        else if (m_st == 2'd1) mn_runs = m_runs + 1;
    end

    // Reference registers: samples kept as (value, run length), ticks from RUN-cycle count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_b1 <= 1'b0; m_b2 <= 1'b0;
            m_run_val <= 1'b0; m_run_len <= DEB_N;
            m_lvl <= 1'b0; m_lvl_d <= 1'b0; m_hold <= 0; m_long_done <= 1'b0; m_short <= 1'b0;
            m_st <= 2'd0; m_runs <= 0;
            m_en <= 1'b0; m_tf <= 1'b0; m_tm <= 1'b0; m_ts <= 1'b0; m_sc <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            m_b1  <= btn;
            m_b2  <= m_b1;
            if (m_stb) begin
                if (m_b2 == m_run_val) m_run_len <= m_run_len + 1;
                else begin
                    m_run_val <= m_b2;
                    m_run_len <= 1;
                end
            end
            m_lvl       <= (m_run_len >= DEB_N) ? m_run_val : m_lvl;
            m_lvl_d     <= m_lvl;
            m_hold      <= !m_lvl ? 0 : ((m_stb && m_hold < HOLD_SAMPLES) ? m_hold + 1 : m_hold);
            m_long_done <= m_hit | (m_lvl & m_long_done);
            m_short     <= m_lvl_d & ~m_lvl & ~m_long_done;
            m_st        <= mn_st;
            m_runs      <= mn_runs;
            m_en        <= (mn_st == 2'd1);
            m_tf        <= (mn_st == 2'd1) && (mn_runs % (1 << FAST_W) == (1 << FAST_W) - 1);
            m_tm        <= (mn_st == 2'd1) && (mn_runs % (1 << MID_W) == (1 << MID_W) - 1);
            m_ts        <= (mn_st == 2'd1) && (mn_runs % (1 << SLOW_W) == (1 << SLOW_W) - 1);
            m_sc        <= m_hit;
        end
    end

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL reset_pre cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_v !== 8'h00) begin
            bad++;
            $display("FAIL reset_async: got %b expected %b", dut_v, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        lat = -1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL reset_post cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (btn_level && lat < 0) lat = i + 1;
        end
        total++;
        if (lat < 1 || lat > 22) begin
            bad++;
            $display("FAIL reset_level_latency: got %0d cycles expected 1..22", lat);
        end
        btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        int g;
        for (int i = 0; i < 60; i++) begin
            btn = ((i / 3) % 2) == 1;
            @(negedge clk);
            total++;
            if (dut_v !== exp_v || btn_level !== 1'b0 || state !== 2'd0) begin
                bad++;
                $display("FAIL bounce cycle %0d: got %b expected %b (level 0, IDLE)", i, dut_v, exp_v);
            end
        end
        g = $urandom_range(3, 10);
        for (int i = 0; i < 28 + g + 8 + 40; i++) begin
            btn = !(i >= 28 && i < 28 + g);
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL glitch cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (i == 28 + g + 7) begin
                total++;
                if (btn_level !== 1'b1) begin
                    bad++;
                    $display("FAIL glitch_level: got %b expected 1 (glitch %0d clk)", btn_level, g);
                end
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL glitch_release cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL long_release_state: got %0d expected 0", state);
        end
    endtask

    task automatic test_short_press();
        int hold, rel, runs, first_f, first_m, first_s, clr;
        hold = $urandom_range(20, 26);
        rel = -1; runs = 0; first_f = 0; first_m = 0; first_s = 0; clr = 0;
        btn = 1'b1;
        for (int i = 0; i < 200 && runs < 40; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL short cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            total++;
            if ((tick_slow && !(tick_mid && tick_fast)) || (tick_mid && !tick_fast)) begin
                bad++;
                $display("FAIL tick_nesting: got f/m/s %b%b%b expected nested", tick_fast, tick_mid, tick_slow);
            end
            if (soft_clr) clr++;
            if (en) begin
                runs++;
                if (rel < 0) rel = i + 1 - hold;
                if (tick_fast && first_f == 0) first_f = runs;
                if (tick_mid && first_m == 0) first_m = runs;
                if (tick_slow && first_s == 0) first_s = runs;
            end
            if (i == hold - 1) btn = 1'b0;
        end
        total++;
        if (rel < 1 || rel > 25) begin
            bad++;
            $display("FAIL short_latency: got %0d expected 1..25", rel);
        end
        total++;
        if (clr != 0) begin
            bad++;
            $display("FAIL short_soft_clr: got %0d pulses expected 0", clr);
        end
        total++;
        if (first_f != 8 || first_m != 16 || first_s != 32) begin
            bad++;
            $display("FAIL first_ticks: got f=%0d m=%0d s=%0d expected 8 16 32", first_f, first_m, first_s);
        end
    endtask

    task automatic test_wrap();
        int nf, nm, ns;
        logic prev_s;
        nf = 0; nm = 0; ns = 0; prev_s = 1'b0;
        btn = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL wrap cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            total++;
            if (prev_s && tick_slow) begin
                bad++;
                $display("FAIL slow_width cycle %0d: got 2-cycle pulse expected 1", i);
            end
            prev_s = tick_slow;
            nf += int'(tick_fast);
            nm += int'(tick_mid);
            ns += int'(tick_slow);
        end
        total++;
        if (nf != 8 || nm != 4 || ns != 2) begin
            bad++;
            $display("FAIL wrap_counts: got f=%0d m=%0d s=%0d expected 8 4 2", nf, nm, ns);
        end
    endtask

    task automatic test_pause_resume();
        int ph, runs, paused, mid_at;
        ph = $urandom_range(20, 26);
        runs = 110;
        paused = 0; mid_at = -1;
        btn = 1'b1;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL pause cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (en) runs++;
            if (state == 2'd2) begin
                paused++;
                total++;
                if ({en, tick_fast, tick_mid, tick_slow} !== 4'b0000) begin
                    bad++;
                    $display("FAIL pause_quiet cycle %0d: got %b expected 0000", i, {en, tick_fast, tick_mid, tick_slow});
                end
            end
            if (i > 70 && tick_mid && mid_at < 0) mid_at = runs;
            if (i == ph - 1) btn = 1'b0;
            if (i == 70) btn = 1'b1;
            if (i == 70 + ph) btn = 1'b0;
        end
        total++;
        if (paused < 15 || state !== 2'd1) begin
            bad++;
            $display("FAIL pause_resume: got paused=%0d state=%0d expected >=15 and 1", paused, state);
        end
        total++;
        if (mid_at < 0 || (mid_at % 16) != 0) begin
            bad++;
            $display("FAIL resume_phase: got mid at run %0d expected multiple of 16", mid_at);
        end
    endtask

    task automatic test_long_press();
        int clr, moved;
        clr = 0; moved = 0;
        btn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if (dut_v !== exp_v) begin
                bad++;
                $display("FAIL long cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (soft_clr) clr++;
            if (i >= 60 && (state !== 2'd0 || en)) moved++;
            if (i == 59) btn = 1'b0;
        end
        total++;
        if (clr != 1) begin
            bad++;
            $display("FAIL long_soft_clr: got %0d pulses expected 1", clr);
        end
        total++;
        if (moved != 0) begin
            bad++;
            $display("FAIL long_release: got %0d non-IDLE cycles expected 0", moved);
        end
    endtask

    task automatic test_random();
        int len;
        for (int s = 0; s < 25; s++) begin
            btn = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                total++;
                if (dut_v !== exp_v) begin
                    bad++;
                    $display("FAIL random seg %0d cycle %0d: got %b expected %b", s, i, dut_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_press();
        test_wrap();
        test_pause_resume();
        test_long_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
